// File: rtl/nrad_seq.sv
// Sequential non-restoring unsigned divider: one quotient bit per cycle,
// one remainder-fix cycle, then a one-cycle done pulse with held results.
module nrad_seq #(
   parameter int N = 8,
   parameter int M = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] X,
   input  logic [M-1:0] Y,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] Q,
   output logic [M-1:0] R,
   output logic         div_zero
);

   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

   state_t         state;
   logic [M:0]     p;
   logic [N-1:0]   a;
   logic [M-1:0]   y_r;
   logic [CW-1:0]  cnt;

   logic [M:0]     y_ext;
   logic [M:0]     p_sh;
   logic [M:0]     p_step;
   logic [M:0]     p_fix;

   // The shift drops the old sign bit; the add/sub brings P back into
   // [-Y, Y), so the modulo-2^(M+1) result is still exact.
   always_comb begin
      y_ext  = {1'b0, y_r};
      p_sh   = {p[M-1:0], a[N-1]};
      p_step = p[M] ? (p_sh + y_ext) : (p_sh - y_ext);
      p_fix  = p[M] ? (p + y_ext) : p;
   end

   // NOTE: every state register uses <= so all updates see pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         p        <= '0;
         a        <= '0;
         y_r      <= '0;
         cnt      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         Q        <= '0;
         R        <= '0;
         div_zero <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
               if (start) begin
                  a        <= X;
                  y_r      <= Y;
                  p        <= '0;
                  cnt      <= CW'(N);
                  div_zero <= (Y == '0);
                  if (Y == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                     Q     <= '1;
                     R     <= X[M-1:0];
                  end else begin
                     state <= ITER;
                     busy  <= 1'b1;
                  end
               end
            end
            ITER: begin
               p   <= p_step;
               a   <= {a[N-2:0], ~p_step[M]};
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) state <= FIX;
            end
            FIX: begin
               p     <= p_fix;
               Q     <= a;
               R     <= p_fix[M-1:0];
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nrad_seq.sv
// Bench for nrad_seq: an 8/4 instance driven by directed vectors and a 4/2
// instance swept exhaustively, both shadowed every cycle by a timing model.
module tb_nrad_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       start8 = 1'b0;
   logic [7:0] X8 = '0;
   logic [3:0] Y8 = '0;
   logic       busy8, done8, dz8;
   logic [7:0] Q8;
   logic [3:0] R8;

   logic       start4 = 1'b0;
   logic [3:0] X4 = '0;
   logic [1:0] Y4 = '0;
   logic       busy4, done4, dz4;
   logic [3:0] Q4;
   logic [1:0] R4;

   int  n_pass = 0;
   int  n_total = 0;
   bit  armed = 0;

   typedef struct {
      int busy; int done; int q; int r; int dz; int left; int pq; int pr;
   } model_t;

   model_t m8 = '{default: 0};
   model_t m4 = '{default: 0};

   nrad_seq #(.N(8), .M(4)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .X(X8), .Y(Y8),
      .busy(busy8), .done(done8), .Q(Q8), .R(R8), .div_zero(dz8)
   );

   nrad_seq #(.N(4), .M(2)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .X(X4), .Y(Y4),
      .busy(busy4), .done(done4), .Q(Q4), .R(R4), .div_zero(dz4)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      else
         n_pass++;
   endtask

   // Timing model: an accepted nonzero divide is busy for N+1 edges, then
   // shows done for one cycle with integer X/Y and X%Y.
   function automatic model_t step(model_t s, logic r, logic st, int x, int y, int n, int m);
      model_t t = s;
      if (r) begin
         t = '{default: 0};
      end else if (s.left > 0) begin
         t.left = s.left - 1;
         if (t.left == 0) begin
            t.busy = 0; t.done = 1; t.q = s.pq; t.r = s.pr;
         end
      end else begin
         t.busy = 0; t.done = 0;
         if (st) begin
            t.dz = (y == 0) ? 1 : 0;
            if (y == 0) begin
               t.done = 1; t.q = (1 << n) - 1; t.r = x % (1 << m);
            end else begin
               t.busy = 1; t.left = n + 1; t.pq = x / y; t.pr = x % y;
            end
         end
      end
      return t;
   endfunction

   always @(posedge clk) begin
      m8 = step(m8, rst, start8, int'(X8), int'(Y8), 8, 4);
      m4 = step(m4, rst, start4, int'(X4), int'(Y4), 4, 2);
   end

   always @(negedge clk) begin
      if (armed) begin
         check("busy8", 32'(busy8), m8.busy);
         check("done8", 32'(done8), m8.done);
         check("q8",    32'(Q8),    m8.q);
         check("r8",    32'(R8),    m8.r);
         check("dz8",   32'(dz8),   m8.dz);
         check("busy4", 32'(busy4), m4.busy);
         check("done4", 32'(done4), m4.done);
         check("q4",    32'(Q4),    m4.q);
         check("r4",    32'(R4),    m4.r);
         check("dz4",   32'(dz4),   m4.dz);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Edges counted after the start edge until done is seen; 40 means timeout.
   task automatic wait8(output int lat);
      lat = 0;
      while (done8 !== 1'b1 && lat < 40) begin
         cyc();
         lat++;
      end
   endtask

   task automatic go8(input int x, input int y);
      start8 = 1'b1; X8 = 8'(x); Y8 = 4'(y);
      cyc();
      start8 = 1'b0;
   endtask

   task automatic op8(input string name, input int x, input int y,
                      input int eq, input int er, input int edz, input int elat);
      int lat;
      go8(x, y);
      wait8(lat);
      check({name, " lat"}, 32'(lat), 32'(elat));
      check({name, " q"},   32'(Q8),  32'(eq));
      check({name, " r"},   32'(R8),  32'(er));
      check({name, " dz"},  32'(dz8), 32'(edz));
      cyc();
   endtask

   initial begin
      int lat;
      rst = 1'b1;
      cyc();
      armed = 1;
      check("reset busy", 32'(busy8), 0);
      check("reset done", 32'(done8), 0);
      check("reset q",    32'(Q8),    0);
      check("reset r",    32'(R8),    0);
      check("reset dz",   32'(dz8),   0);
      cyc();
      rst = 1'b0;
      cyc();

      // Nominal and boundary divides; done on the (N+1)th edge after start.
      op8("nominal",  200, 7,  28,  4, 0, 9);
      op8("x<y",        5, 9,   0,  5, 0, 9);
      op8("y=1",      255, 1, 255,  0, 0, 9);
      op8("y=15",     255, 15, 17,  0, 0, 9);
      op8("zero div", 8'hA7, 0, 8'hFF, 4'h7, 1, 0);
      check("zero div busy", 32'(busy8), 0);
      op8("after zero", 100, 10, 10, 0, 0, 9);

      // start with new operands mid-ITER must not disturb the operation.
      go8(200, 7);
      cyc(); cyc(); cyc();
      start8 = 1'b1; X8 = 8'd9; Y8 = 4'd2;
      cyc();
      start8 = 1'b0;
      wait8(lat);
      check("ignore lat", 32'(lat), 5);
      check("ignore q", 32'(Q8), 28);
      check("ignore r", 32'(R8), 4);
      cyc();

      // start held through done launches the next divide with no gap.
      start8 = 1'b1; X8 = 8'd100; Y8 = 4'd3;
      cyc();
      X8 = 8'd50; Y8 = 4'd6;
      wait8(lat);
      check("b2b first lat", 32'(lat), 9);
      check("b2b first q", 32'(Q8), 33);
      check("b2b first r", 32'(R8), 1);
      cyc();
      start8 = 1'b0;
      check("b2b busy", 32'(busy8), 1);
      wait8(lat);
      check("b2b second lat", 32'(lat), 9);
      check("b2b second q", 32'(Q8), 8);
      check("b2b second r", 32'(R8), 2);
      cyc();

      // Reset during the 4th ITER cycle clears everything, no done follows.
      go8(200, 7);
      cyc(); cyc(); cyc();
      rst = 1'b1; start8 = 1'b1;
      cyc();
      rst = 1'b0; start8 = 1'b0;
      check("rst busy", 32'(busy8), 0);
      check("rst done", 32'(done8), 0);
      check("rst q",    32'(Q8),    0);
      check("rst r",    32'(R8),    0);
      for (int i = 0; i < 12; i++) begin
         check("rst no done", 32'(done8), 0);
         cyc();
      end
      op8("after rst", 255, 15, 17, 0, 0, 9);

      // Exhaustive sweep of the 4/2 instance.
      for (int x = 0; x < 16; x++) begin
         for (int y = 0; y < 4; y++) begin
            start4 = 1'b1; X4 = 4'(x); Y4 = 2'(y);
            cyc();
            start4 = 1'b0;
            lat = 0;
            while (done4 !== 1'b1 && lat < 20) begin
               cyc();
               lat++;
            end
            check("sweep lat", 32'(lat), (y == 0) ? 0 : 5);
            check("sweep q", 32'(Q4), (y == 0) ? 15 : x / y);
            check("sweep r", 32'(R4), (y == 0) ? x % 4 : x % y);
            check("sweep dz", 32'(dz4), (y == 0) ? 1 : 0);
            cyc();
         end
      end

      cyc();
      armed = 0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
